// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types and constants for the character-LCD controller
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC,
        ST_IDLE
    } lcd_state_e;

    localparam int LCD_INIT_LEN = 6;
    localparam int LCD_IDX_W    = 3;

    // Entry [0] is sent first.
    localparam logic [LCD_INIT_LEN-1:0][7:0] LCD_INIT_ROM = {
        8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
    };

    localparam int LCD_BL_BIT      = 31;
    localparam int LCD_RS_BIT      = 9;
    localparam int LCD_ST_BUSY_BIT = 31;
    localparam int LCD_ST_OVR_BIT  = 30;
    localparam int LCD_ST_INIT_BIT = 29;

    // Clear display / return home need the long execution wait.
    function automatic logic lcd_is_long(input logic rs, input logic [7:0] b);
        return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter that saturates at zero
module lcd_timer #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style 8-bit character LCD controller with autonomous init
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int PWRUP_CYC = 1_000_000,
    parameter int SETUP_CYC = 3,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 3,
    parameter int SHORT_CYC = 2_000,
    parameter int LONG_CYC  = 80_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_status,
    output logic        o_busy,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(PULSE_CYC, HOLD_CYC)),
                                  max2(SHORT_CYC, LONG_CYC));
    localparam int TW = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    // A zero-length phase still lasts one cycle.
    function automatic logic [TW-1:0] cyc_m1(input int c);
        return (c <= 1) ? '0 : TW'(c - 1);
    endfunction

    localparam logic [TW-1:0] PWRUP_M1 = cyc_m1(PWRUP_CYC);
    localparam logic [TW-1:0] SETUP_M1 = cyc_m1(SETUP_CYC);
    localparam logic [TW-1:0] PULSE_M1 = cyc_m1(PULSE_CYC);
    localparam logic [TW-1:0] HOLD_M1  = cyc_m1(HOLD_CYC);
    localparam logic [TW-1:0] SHORT_M1 = cyc_m1(SHORT_CYC);
    localparam logic [TW-1:0] LONG_M1  = cyc_m1(LONG_CYC);

    lcd_state_e           state_q, state_d;
    logic [LCD_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]           data_q, data_d;
    logic                 rs_q, rs_d;
    logic                 blon_q, blon_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 lcd_on_q, lcd_on_d;
    logic                 ovr_q, ovr_d;
    logic                 init_done_q, init_done_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_done;

    logic                 unused_wr_bits;
    assign unused_wr_bits = ^{i_wr_data[30:10], i_wr_data[8]};

    // Reset value covers the first power-up wait without a separate load.
    lcd_timer #(
        .W       (TW),
        .RST_VAL (PWRUP_M1)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (tmr_load),
        .i_val   (tmr_val),
        .o_done  (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rs_d     = rs_q;
        blon_d   = blon_q;
        lcd_on_d = 1'b1;
        ovr_d    = ovr_q | (i_wr_en & busy_q);

        unique case (state_q)
            ST_PWRUP: begin
                if (tmr_done) state_d = ST_INIT_LD;
            end
            ST_INIT_LD: begin
                data_d  = LCD_INIT_ROM[idx_q];
                rs_d    = 1'b0;
                idx_d   = idx_q + LCD_IDX_W'(1);
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (tmr_done) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (tmr_done) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_done) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (tmr_done) begin
                    state_d = (idx_q == LCD_IDX_W'(LCD_INIT_LEN)) ? ST_IDLE : ST_INIT_LD;
                end
            end
            ST_IDLE: begin
                if (i_wr_en && !busy_q) begin
                    data_d  = i_wr_data[7:0];
                    rs_d    = i_wr_data[LCD_RS_BIT];
                    blon_d  = i_wr_data[LCD_BL_BIT];
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_PWRUP;
        endcase

        en_d        = (state_d == ST_PULSE);
        busy_d      = (state_d != ST_IDLE);
        init_done_d = init_done_q | (state_d == ST_IDLE);
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        unique case (state_d)
            ST_SETUP: tmr_val = SETUP_M1;
            ST_PULSE: tmr_val = PULSE_M1;
            ST_HOLD:  tmr_val = HOLD_M1;
            ST_EXEC:  tmr_val = lcd_is_long(rs_d, data_d) ? LONG_M1 : SHORT_M1;
            default:  tmr_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_PWRUP;
            idx_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            blon_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b1;
            lcd_on_q    <= 1'b0;
            ovr_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            blon_q      <= blon_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            lcd_on_q    <= lcd_on_d;
            ovr_q       <= ovr_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        o_status                  = '0;
        o_status[LCD_ST_BUSY_BIT] = busy_q;
        o_status[LCD_ST_OVR_BIT]  = ovr_q;
        o_status[LCD_ST_INIT_BIT] = init_done_q;
    end

    assign o_busy     = busy_q;
    assign o_lcd_on   = lcd_on_q;
    assign o_lcd_blon = blon_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl against a timeline reference model
module tb_lcd_ctrl;

    localparam int PW = 20;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int SH = 10;
    localparam int LG = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] status;
    logic        busy, lcd_on, blon, en, rs, rw;
    logic [7:0]  data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .PWRUP_CYC (PW),
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H),
        .SHORT_CYC (SH),
        .LONG_CYC  (LG)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_status   (status),
        .o_busy     (busy),
        .o_lcd_on   (lcd_on),
        .o_lcd_blon (blon),
        .o_lcd_en   (en),
        .o_lcd_rs   (rs),
        .o_lcd_rw   (rw),
        .o_lcd_data (data)
    );

    int checks = 0;
    int errors = 0;
    int t;
    int cl[$];
    int cb[$];
    int crs[$];
    int cbl[$];
    int ovr_t;
    int init_free;
    int en_log[$];
    logic prev_en;
    int rom_exp[6] = '{'h38, 'h38, 'h38, 'h0C, 'h01, 'h06};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exec_of(input int b, input int r);
        return (r == 0 && b >= 1 && b <= 3) ? LG : SH;
    endfunction

    function automatic int free_of(input int k);
        return cl[k] + 1 + S + P + H + exec_of(cb[k], crs[k]);
    endfunction

    function automatic int last_free();
        return free_of(cl.size() - 1);
    endfunction

    task automatic push_cmd(input int l, input int b, input int r, input int bl);
        cl.push_back(l);
        cb.push_back(b);
        crs.push_back(r);
        cbl.push_back(bl);
    endtask

    task automatic start_init();
        int l;
        cl.delete(); cb.delete(); crs.delete(); cbl.delete();
        l = PW;
        for (int k = 0; k < 6; k++) begin
            push_cmd(l, rom_exp[k], 0, 0);
            l = last_free();
        end
        init_free = l;
    endtask

    task automatic check_model();
        int k;
        int e_data, e_rs, e_bl, e_en, e_busy, e_ovr, e_init;
        k = -1;
        for (int i = 0; i < cl.size(); i++) if (cl[i] < t) k = i;
        e_data = (k < 0) ? 0 : cb[k];
        e_rs   = (k < 0) ? 0 : crs[k];
        e_bl   = (k < 0) ? 0 : cbl[k];
        e_en   = (k >= 0 && t >= cl[k] + 1 + S && t <= cl[k] + S + P) ? 1 : 0;
        e_busy = (t < last_free()) ? 1 : 0;
        e_ovr  = (ovr_t >= 0 && t > ovr_t) ? 1 : 0;
        e_init = (t >= init_free) ? 1 : 0;
        chk("en", 32'(en), 32'(e_en));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("data", 32'(data), 32'(e_data));
        chk("rs", 32'(rs), 32'(e_rs));
        chk("blon", 32'(blon), 32'(e_bl));
        chk("rw", 32'(rw), 32'd0);
        chk("lcd_on", 32'(lcd_on), (t >= 1) ? 32'd1 : 32'd0);
        chk("status", status, {e_busy[0], e_ovr[0], e_init[0], 29'd0});
    endtask

    task automatic cyc(input logic we, input logic [31:0] d);
        wr_en   = we;
        wr_data = d;
        @(negedge clk);
        check_model();
        if (en && !prev_en) en_log.push_back(int'(data));
        prev_en = en;
        if (we) begin
            if (t < last_free()) begin
                if (ovr_t < 0) ovr_t = t;
            end else begin
                push_cmd(t, int'(d[7:0]), int'(d[9]), int'(d[31]));
            end
        end
        @(posedge clk);
        #1;
        t++;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_status", status, 32'h8000_0000);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_rs", 32'(rs), 32'd0);
        chk("rst_blon", 32'(blon), 32'd0);
        chk("rst_lcd_on", 32'(lcd_on), 32'd0);
        repeat (n - 1) @(posedge clk);
        if (n == 1) @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        ovr_t = -1;
        start_init();
        en_log.delete();
        prev_en = 1'b0;
    endtask

    task automatic check_init_log();
        chk("init_pulses", 32'(en_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < en_log.size(); k++) chk("init_byte", 32'(en_log[k]), 32'(rom_exp[k]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        @(posedge clk);
        #1;

        // Power-up and autonomous init.
        do_reset(3);
        idle(160);
        check_init_log();

        // Data write 'A', then clear with the long wait.
        cyc(1'b1, 32'h0000_0241);
        idle(20);
        cyc(1'b1, 32'h0000_0001);
        idle(40);

        // Write during busy is dropped and sets sticky overrun.
        cyc(1'b1, 32'h0000_0241);
        idle(5);
        cyc(1'b1, 32'h0000_0242);
        idle(15);
        chk("overrun_set", 32'(status[30]), 32'd1);
        do_reset(2);
        cyc(1'b1, 32'h0000_0155);
        idle(160);
        check_init_log();

        // Reset while EN is high.
        cyc(1'b1, 32'h0000_0241);
        idle(3);
        chk("en_before_reset", 32'(en), 32'd1);
        do_reset(1);
        idle(160);
        check_init_log();

        // Backlight follows bit 31 of each accepted write.
        cyc(1'b1, 32'h8000_0248);
        chk("blon_on", 32'(blon), 32'd1);
        idle(25);
        cyc(1'b1, 32'h0000_0248);
        chk("blon_off", 32'(blon), 32'd0);
        idle(25);

        // Random writes, including ones that land while busy.
        for (int i = 0; i < 1500; i++) begin
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d[7:0] = 8'($urandom_range(0, 3));
            cyc(($urandom_range(0, 7) == 0), d);
        end
        idle(45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
